// File: rtl/outerprodrc_seq.sv
// Tile sequencer for the outer-product rate-coded GEMM array: 2-entry operand buffer, CLR/RUN/DRAIN/CAP control.
// Optional busy/stall performance counters are enabled with `define OUTERPRODRC_SEQ_PERF_EN.
module outerprodrc_seq #(
  parameter int HIDDEN      = 4,
  parameter int ROWNUM      = 4,
  parameter int COLNUM      = 4,
  parameter int BITWIDTH    = 8,
  parameter int OUTBITWIDTH = 9,
  parameter int DRAIN_LAT   = 1
) (
  input  logic                                   iClk,
  input  logic                                   iRstN,
  input  logic                                   iClr,
  input  logic                                   iValid,
  output logic                                   oReady,
  input  logic [HIDDEN*ROWNUM*BITWIDTH-1:0]      iRow,
  input  logic [HIDDEN*COLNUM*BITWIDTH-1:0]      iCol,
  output logic [HIDDEN*ROWNUM*BITWIDTH-1:0]      oArrData0,
  output logic [HIDDEN*COLNUM*BITWIDTH-1:0]      oArrData1,
  output logic                                   oArrEn,
  output logic                                   oArrClr,
  input  logic [ROWNUM*COLNUM*2*OUTBITWIDTH-1:0] iArrSum,
  output logic                                   oValid,
  input  logic                                   iReady,
  output logic [ROWNUM*COLNUM*2*OUTBITWIDTH-1:0] oSum
`ifdef OUTERPRODRC_SEQ_PERF_EN
  ,
  output logic [31:0]                            oBusyCnt,
  output logic [31:0]                            oStallCnt
`endif
);

  localparam int RW     = HIDDEN * ROWNUM * BITWIDTH;
  localparam int CW     = HIDDEN * COLNUM * BITWIDTH;
  localparam int SW     = ROWNUM * COLNUM * 2 * OUTBITWIDTH;
  localparam int RUNLEN = 1 << BITWIDTH;
  localparam int CNTW   = BITWIDTH + 1;
  localparam int DW     = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(RUNLEN - 1);
  localparam logic [DW-1:0]   DRN_LAST = DW'(DRAIN_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_CAP} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic [1:0]      occ_q, occ_d;
  logic            hd_q, hd_d;
  logic [RW-1:0]   row_buf_q [2];
  logic [RW-1:0]   row_buf_d [2];
  logic [CW-1:0]   col_buf_q [2];
  logic [CW-1:0]   col_buf_d [2];
  logic [RW-1:0]   arr_d0_q, arr_d0_d;
  logic [CW-1:0]   arr_d1_q, arr_d1_d;
  logic            arr_en_q, arr_en_d;
  logic            arr_clr_q, arr_clr_d;
  logic            vld_q, vld_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic            push, pop, can_cap, wr_idx;
`ifdef OUTERPRODRC_SEQ_PERF_EN
  logic [31:0]     busy_q, busy_d, stall_q, stall_d;
`endif

  assign oReady = (occ_q != 2'd2);

  always_comb begin
    can_cap   = !vld_q || iReady;
    push      = iValid && oReady && !iClr;
    pop       = (state_q == S_CAP) && can_cap;
    wr_idx    = hd_q ^ occ_q[0];
    occ_d     = occ_q + {1'b0, push} - {1'b0, pop};
    state_d   = state_q;
    cnt_d     = cnt_q;
    drn_d     = drn_q;
    hd_d      = hd_q;
    row_buf_d = row_buf_q;
    col_buf_d = col_buf_q;
    vld_d     = vld_q;
    sum_d     = sum_q;
    if (push) begin
      row_buf_d[wr_idx] = iRow;
      col_buf_d[wr_idx] = iCol;
    end
    case (state_q)
      S_IDLE:  if (occ_d != 2'd0) state_d = S_CLR;
      S_CLR: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          drn_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_LAST) state_d = S_CAP;
        else                   drn_d   = drn_q + DW'(1);
      end
      S_CAP: begin
        if (can_cap) begin
          sum_d   = iArrSum;
          state_d = (occ_d != 2'd0) ? S_CLR : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop)         hd_d  = ~hd_q;
    if (pop)         vld_d = 1'b1;
    else if (iReady) vld_d = 1'b0;
    // Soft clear wins over any push, pop or capture in the same cycle.
    if (iClr) begin
      state_d = S_IDLE;
      occ_d   = 2'd0;
      hd_d    = 1'b0;
      vld_d   = 1'b0;
      cnt_d   = '0;
      drn_d   = '0;
    end
    arr_en_d  = (state_d == S_RUN);
    arr_clr_d = (state_d == S_CLR) || iClr;
    arr_d0_d  = row_buf_d[hd_d];
    arr_d1_d  = col_buf_d[hd_d];
`ifdef OUTERPRODRC_SEQ_PERF_EN
    busy_d  = busy_q;
    stall_d = stall_q;
    if (state_q != S_IDLE && busy_q != '1)               busy_d  = busy_q + 32'd1;
    if (state_q == S_CAP && !can_cap && stall_q != '1)   stall_d = stall_q + 32'd1;
    if (iClr) begin
      busy_d  = '0;
      stall_d = '0;
    end
`endif
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      drn_q     <= '0;
      occ_q     <= 2'd0;
      hd_q      <= 1'b0;
      row_buf_q <= '{default: '0};
      col_buf_q <= '{default: '0};
      arr_d0_q  <= '0;
      arr_d1_q  <= '0;
      arr_en_q  <= 1'b0;
      arr_clr_q <= 1'b0;
      vld_q     <= 1'b0;
      sum_q     <= '0;
`ifdef OUTERPRODRC_SEQ_PERF_EN
      busy_q    <= '0;
      stall_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drn_q     <= drn_d;
      occ_q     <= occ_d;
      hd_q      <= hd_d;
      row_buf_q <= row_buf_d;
      col_buf_q <= col_buf_d;
      arr_d0_q  <= arr_d0_d;
      arr_d1_q  <= arr_d1_d;
      arr_en_q  <= arr_en_d;
      arr_clr_q <= arr_clr_d;
      vld_q     <= vld_d;
      sum_q     <= sum_d;
`ifdef OUTERPRODRC_SEQ_PERF_EN
      busy_q    <= busy_d;
      stall_q   <= stall_d;
`endif
    end
  end

  assign oArrData0 = arr_d0_q;
  assign oArrData1 = arr_d1_q;
  assign oArrEn    = arr_en_q;
  assign oArrClr   = arr_clr_q;
  assign oValid    = vld_q;
  assign oSum      = sum_q;
`ifdef OUTERPRODRC_SEQ_PERF_EN
  assign oBusyCnt  = busy_q;
  assign oStallCnt = stall_q;
`endif

endmodule

// File: tb/tb_outerprodrc_seq.sv
// Self-checking bench for outerprodrc_seq: random operand tiles, a behavioural stand-in for the array,
// and per-scenario timing/data expectations derived from the sequencing rules.
module tb_outerprodrc_seq;
  localparam int HIDDEN = 4, ROWNUM = 4, COLNUM = 4, BITWIDTH = 4, OUTBITWIDTH = 9, DRAIN_LAT = 1;
  localparam int RUNLEN = 1 << BITWIDTH;
  localparam int RW = HIDDEN * ROWNUM * BITWIDTH;
  localparam int CW = HIDDEN * COLNUM * BITWIDTH;
  localparam int SW = ROWNUM * COLNUM * 2 * OUTBITWIDTH;
  localparam int LAT = 3 + RUNLEN + DRAIN_LAT;   // push cycle to result-valid cycle
  localparam int PER = RUNLEN + DRAIN_LAT + 2;   // spacing of back-to-back results

  logic iClk = 1'b0, iRstN = 1'b0, iClr = 1'b0, iValid = 1'b0, iReady = 1'b1;
  logic oReady, oArrEn, oArrClr, oValid;
  logic [RW-1:0] iRow = '0, oArrData0;
  logic [CW-1:0] iCol = '0, oArrData1;
  logic [SW-1:0] iArrSum, oSum;
`ifdef OUTERPRODRC_SEQ_PERF_EN
  logic [31:0] oBusyCnt, oStallCnt;
`endif
  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  logic [31:0] acc;

  outerprodrc_seq #(.HIDDEN(HIDDEN), .ROWNUM(ROWNUM), .COLNUM(COLNUM), .BITWIDTH(BITWIDTH),
                    .OUTBITWIDTH(OUTBITWIDTH), .DRAIN_LAT(DRAIN_LAT)) dut (
    .iClk(iClk), .iRstN(iRstN), .iClr(iClr), .iValid(iValid), .oReady(oReady),
    .iRow(iRow), .iCol(iCol), .oArrData0(oArrData0), .oArrData1(oArrData1),
    .oArrEn(oArrEn), .oArrClr(oArrClr), .iArrSum(iArrSum),
    .oValid(oValid), .iReady(iReady), .oSum(oSum)
`ifdef OUTERPRODRC_SEQ_PERF_EN
    , .oBusyCnt(oBusyCnt), .oStallCnt(oStallCnt)
`endif
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  // Array stand-in: counts enabled cycles since the last clear and folds in the presented operands.
  function automatic logic [SW-1:0] arr_fn(input logic [31:0] a, input logic [RW-1:0] r, input logic [CW-1:0] c);
    return {a, r, c, r ^ c, r + c};
  endfunction

  always @(negedge iClk or negedge iRstN) begin
    if (!iRstN)       acc <= 32'd0;
    else if (oArrClr) acc <= 32'd0;
    else if (oArrEn)  acc <= acc + 32'd1;
  end
  assign iArrSum = arr_fn(acc, oArrData0, oArrData1);

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [RW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    iRstN = 1'b0;
    tick(); tick();
    n_chk++;
    if ({oArrEn, oArrClr, oValid} !== 3'b000) $display("FAIL reset_ctrl: en/clr/vld=%b required 000", {oArrEn, oArrClr, oValid});
    else n_pass++;
    n_chk++;
    if (oSum !== '0 || oArrData0 !== '0 || oArrData1 !== '0) $display("FAIL reset_data: sum=%h d0=%h d1=%h required all 0", oSum, oArrData0, oArrData1);
    else n_pass++;
    iRstN = 1'b1;
    tick();
    n_chk++;
    if (oReady !== 1'b1) $display("FAIL reset_ready: oReady=%b required 1", oReady);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [RW-1:0] r;
    logic [CW-1:0] c;
`ifdef OUTERPRODRC_SEQ_PERF_EN
    logic [31:0] b0;
    b0 = oBusyCnt;
`endif
    r = rnd64(); c = rnd64();
    iReady = 1'b1; iRow = r; iCol = c; iValid = 1'b1;
    tick();
    iValid = 1'b0;
    n_chk++;
    if ({oArrClr, oArrEn} !== 2'b10) $display("FAIL single_clr: clr/en=%b required 10", {oArrClr, oArrEn});
    else n_pass++;
    n_chk++;
    if (oArrData0 !== r || oArrData1 !== c) $display("FAIL single_data: d0=%h d1=%h required %h %h", oArrData0, oArrData1, r, c);
    else n_pass++;
    tick();
    for (int i = 0; i < RUNLEN; i++) begin
      n_chk++;
      if ({oArrEn, oArrClr} !== 2'b10) $display("FAIL single_run[%0d]: en/clr=%b required 10", i, {oArrEn, oArrClr});
      else n_pass++;
      tick();
    end
    for (int i = 0; i <= DRAIN_LAT; i++) begin
      n_chk++;
      if ({oArrEn, oValid} !== 2'b00) $display("FAIL single_drain[%0d]: en/vld=%b required 00", i, {oArrEn, oValid});
      else n_pass++;
      tick();
    end
    n_chk++;
    if (oValid !== 1'b1) $display("FAIL single_valid: oValid=%b required 1", oValid);
    else n_pass++;
    n_chk++;
    if (oSum !== arr_fn(RUNLEN, r, c)) $display("FAIL single_sum: oSum=%h required %h", oSum, arr_fn(RUNLEN, r, c));
    else n_pass++;
`ifdef OUTERPRODRC_SEQ_PERF_EN
    n_chk++;
    if (oBusyCnt - b0 !== 32'(PER)) $display("FAIL single_busy: delta=%0d required %0d", oBusyCnt - b0, PER);
    else n_pass++;
`endif
    tick();
    n_chk++;
    if (oValid !== 1'b0) $display("FAIL single_valid_clear: oValid=%b required 0", oValid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] r [3];
    logic [CW-1:0] c [3];
    logic exp_rdy [3];
    int t;
    int vc[$];
    logic [SW-1:0] vs[$];
    exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b0;
    iReady = 1'b1;
    t = cyc;
    for (int k = 0; k < 3; k++) begin
      r[k] = rnd64(); c[k] = rnd64();
      n_chk++;
      if (oReady !== exp_rdy[k]) $display("FAIL b2b_ready[%0d]: oReady=%b required %b", k, oReady, exp_rdy[k]);
      else n_pass++;
      iRow = r[k]; iCol = c[k]; iValid = 1'b1;
      tick();
    end
    iValid = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (oValid === 1'b1) begin vc.push_back(cyc); vs.push_back(oSum); end
      tick();
    end
    n_chk++;
    if (vc.size() != 2) $display("FAIL b2b_count: results=%0d required 2", vc.size());
    else n_pass++;
    if (vc.size() >= 2) begin
      n_chk++;
      if (vc[0] != t + LAT) $display("FAIL b2b_first_cycle: cycle=%0d required %0d", vc[0], t + LAT);
      else n_pass++;
      n_chk++;
      if (vc[1] - vc[0] != PER) $display("FAIL b2b_spacing: gap=%0d required %0d", vc[1] - vc[0], PER);
      else n_pass++;
      n_chk++;
      if (vs[0] !== arr_fn(RUNLEN, r[0], c[0]) || vs[1] !== arr_fn(RUNLEN, r[1], c[1]))
        $display("FAIL b2b_sums: got %h / %h required %h / %h", vs[0], vs[1], arr_fn(RUNLEN, r[0], c[0]), arr_fn(RUNLEN, r[1], c[1]));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] ra, rb;
    logic [CW-1:0] ca, cb;
    int t, v1;
`ifdef OUTERPRODRC_SEQ_PERF_EN
    logic [31:0] s0;
    s0 = oStallCnt;
`endif
    ra = rnd64(); ca = rnd64(); rb = rnd64(); cb = rnd64();
    iReady = 1'b0;
    t = cyc;
    iRow = ra; iCol = ca; iValid = 1'b1; tick();
    iRow = rb; iCol = cb; tick();
    iValid = 1'b0;
    v1 = -1;
    for (int i = 0; i < 100 && v1 < 0; i++) begin
      if (oValid === 1'b1) v1 = cyc;
      else tick();
    end
    n_chk++;
    if (v1 != t + LAT) $display("FAIL bp_first_cycle: cycle=%0d required %0d", v1, t + LAT);
    else n_pass++;
    if (v1 >= 0) begin
      for (int i = 0; i < 50; i++) begin
        n_chk++;
        if (oValid !== 1'b1 || oSum !== arr_fn(RUNLEN, ra, ca)) $display("FAIL bp_hold[%0d]: vld=%b sum=%h required 1 %h", i, oValid, oSum, arr_fn(RUNLEN, ra, ca));
        else n_pass++;
        if (i >= RUNLEN + DRAIN_LAT + 1) begin
          n_chk++;
          if ({oArrEn, oArrClr} !== 2'b00) $display("FAIL bp_cap_wait[%0d]: en/clr=%b required 00", i, {oArrEn, oArrClr});
          else n_pass++;
        end
        tick();
      end
`ifdef OUTERPRODRC_SEQ_PERF_EN
      n_chk++;
      if (oStallCnt - s0 !== 32'(50 - (RUNLEN + DRAIN_LAT + 1))) $display("FAIL bp_stall_cnt: delta=%0d required %0d", oStallCnt - s0, 50 - (RUNLEN + DRAIN_LAT + 1));
      else n_pass++;
`endif
      iReady = 1'b1;
      tick();
      n_chk++;
      if (oValid !== 1'b1 || oSum !== arr_fn(RUNLEN, rb, cb)) $display("FAIL bp_second: vld=%b sum=%h required 1 %h", oValid, oSum, arr_fn(RUNLEN, rb, cb));
      else n_pass++;
      tick();
      n_chk++;
      if (oValid !== 1'b0) $display("FAIL bp_drained: oValid=%b required 0", oValid);
      else n_pass++;
    end
    iReady = 1'b1;
  endtask

  task automatic test_push_pop_full();
    logic [RW-1:0] r [3];
    logic [CW-1:0] c [3];
    logic [SW-1:0] vs[$];
    int t, bad;
    logic rdy_after;
    for (int k = 0; k < 3; k++) begin r[k] = rnd64(); c[k] = rnd64(); end
    iReady = 1'b1;
    bad = 0;
    rdy_after = 1'b0;
    t = cyc;
    for (int k = 0; k < 150; k++) begin
      if (oValid === 1'b1) vs.push_back(oSum);
      if (k >= 2 && k <= LAT - 1 && oReady !== 1'b0) bad++;
      if (k == LAT) rdy_after = oReady;
      iValid = (k <= LAT);
      iRow = r[(k > 2) ? 2 : k];
      iCol = c[(k > 2) ? 2 : k];
      tick();
    end
    iValid = 1'b0;
    n_chk++;
    if (bad != 0) $display("FAIL ppf_ready_full: %0d cycles with oReady=1, required 0", bad);
    else n_pass++;
    n_chk++;
    if (rdy_after !== 1'b1) $display("FAIL ppf_ready_after_pop: oReady=%b required 1", rdy_after);
    else n_pass++;
    n_chk++;
    if (vs.size() != 3) $display("FAIL ppf_count: results=%0d required 3", vs.size());
    else n_pass++;
    for (int k = 0; k < 3 && k < vs.size(); k++) begin
      n_chk++;
      if (vs[k] !== arr_fn(RUNLEN, r[k], c[k])) $display("FAIL ppf_order[%0d]: sum=%h required %h", k, vs[k], arr_fn(RUNLEN, r[k], c[k]));
      else n_pass++;
    end
  endtask

  task automatic test_soft_clear();
    int nv, nen;
    iReady = 1'b1;
    iRow = rnd64(); iCol = rnd64(); iValid = 1'b1; tick();
    iRow = rnd64(); iCol = rnd64(); tick();
    iValid = 1'b0;
    repeat (5) tick();
    n_chk++;
    if (oArrEn !== 1'b1) $display("FAIL clr_pre_run: oArrEn=%b required 1", oArrEn);
    else n_pass++;
    iClr = 1'b1; iValid = 1'b1; iRow = rnd64(); iCol = rnd64();
    tick();
    iClr = 1'b0; iValid = 1'b0;
    n_chk++;
    if ({oArrEn, oArrClr, oValid, oReady} !== 4'b0101) $display("FAIL clr_next: en/clr/vld/rdy=%b required 0101", {oArrEn, oArrClr, oValid, oReady});
    else n_pass++;
    nv = 0; nen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (oValid !== 1'b0) nv++;
      if (oArrEn !== 1'b0 || oArrClr !== 1'b0) nen++;
    end
    n_chk++;
    if (nv != 0 || nen != 0) $display("FAIL clr_quiet: valid cycles=%0d en/clr cycles=%0d required 0 0", nv, nen);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    iReady = 1'b1;
    iRow = rnd64(); iCol = rnd64(); iValid = 1'b1; tick();
    iValid = 1'b0;
    repeat (6) tick();
    iRstN = 1'b0;
    #1;
    n_chk++;
    if ({oArrEn, oArrClr, oValid} !== 3'b000 || oSum !== '0 || oArrData0 !== '0 || oArrData1 !== '0)
      $display("FAIL rst_mid_outputs: en/clr/vld=%b sum=%h d0=%h required 000 and zeros", {oArrEn, oArrClr, oValid}, oSum, oArrData0);
    else n_pass++;
    repeat (3) tick();
    iRstN = 1'b1;
    tick();
    n_chk++;
    if (oReady !== 1'b1 || oArrEn !== 1'b0) $display("FAIL rst_mid_release: rdy=%b en=%b required 1 0", oReady, oArrEn);
    else n_pass++;
    test_single();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    repeat (3) tick();
    test_single();
    repeat (3) tick();
    test_back_to_back();
    repeat (3) tick();
    test_backpressure();
    repeat (3) tick();
    test_push_pop_full();
    repeat (3) tick();
    test_soft_clear();
    repeat (3) tick();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
